walksat_core: RTL and testbench
===============================

Name: walksat_core

Overview:
Parametrised stochastic local-search 3SAT engine that succeeds the static PLA clause evaluator. It holds a run-time programmable clause store and evaluates all clauses in parallel, AND-of-ORs. It then runs WalkSAT-style random flips driven by an internal 32-bit LFSR, bounded by flip and restart limits. It reports a satisfying assignment or failure to the host/sequencer.

Parameters:
N, 3, number of variables (1..32)
M, 4, number of clause slots
K, 3, literals per clause (1..4)
MAX_FLIPS, 8, flips per try before restart
MAX_TRIES, 4, tries before reporting failure
SEED, 32'h1, LFSR seed (0 is forced to 1)

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  synchronous, active-low reset
cfg_we  in  1  clause write strobe
cfg_idx  in  clog2(M)  clause slot index
cfg_en  in  1  slot enable written with the clause
cfg_lits  in  K*LW  K literals, LW=clog2(N)+1; bit LW-1 = negate, low bits = var index
start  in  1  begin search
busy  out  1  search in progress
done  out  1  search finished, level
sat  out  1  valid when done: 1 = satisfying assignment found
values  out  N  current assignment
flip_count  out  clog2(MAX_FLIPS+1)  flips in current try
try_count  out  clog2(MAX_TRIES+1)  tries started

Behaviour:
- Reset (reset==0 at edge): state IDLE; busy, done, sat, values, flip_count, try_count = 0; all clause enables cleared; LFSR = SEED.
- LFSR: 32-bit Galois, taps 0x80200003. Advances every non-reset cycle.
- Literal value: var index >= N means constant 0, used as padding. Otherwise values[idx] XOR negate.
- Clause satisfied = OR of its literals. Disabled slot counts as satisfied. all_sat = AND over M slots.
- Config: cfg_we writes slot cfg_idx in IDLE/DONE only. It is ignored while busy.
- FSM: IDLE, INIT, EVAL, PICK, FLIP, DONE.
- IDLE/DONE with start=1 → INIT. This sets busy=1, done=0, sat=0, try_count=1, flip_count=0. start while busy is ignored.
- INIT: values <= lfsr[N-1:0]; flip_count <= 0 → EVAL.
- EVAL: registers the sat vector.
  - If all_sat → DONE, with sat=1, done=1, busy=0.
  - Else if flip_count==MAX_FLIPS:
    - if try_count==MAX_TRIES → DONE with sat=0, done=1, busy=0;
    - else try_count++ → INIT.
  - Else → PICK.
- PICK: start = lfsr[clog2(M)-1:0] mod M. Selects the first unsatisfied clause at or after start, with wrap-around. It is a combinational rotate-priority encoder, one cycle → FLIP.
- FLIP: literal j = lfsr[1:0] mod K.
  - If literal j is padding, use the lowest-index valid literal.
  - If the clause has no valid literal, no variable flips.
  - Otherwise values[var] toggles.
  - flip_count++ → EVAL.
- Latency: start at cycle t → INIT t+1, EVAL t+2. For a formula already satisfied, done=1 from t+3.
  - Each flip costs 3 cycles (EVAL, PICK, FLIP).
  - Each restart costs 1 extra cycle.
- DONE holds values, sat, done, and the counters until the next start or reset.
- Reset mid-search aborts immediately to the reset state. Clause store is lost (enables cleared).
- cfg_we and start in the same IDLE cycle: the write completes, and the search uses the new clause.

Test Plan:
1. After reset, no clauses programmed, start pulse at t → done=1, sat=1 from t+3; flip_count=0, try_count=1.
2. N=3: slot0 = (x0, pad, pad) enabled, start → done, sat=1, values[0]=1; flip_count ≤ 1.
3. Slot0=(x0), slot1=(¬x0), MAX_FLIPS=4, MAX_TRIES=2 → done, sat=0, try_count=2, flip_count=4. Completes within 2*(1+1+4*3)+3 cycles of start.
4. N=4, M=6, known satisfiable 3SAT instance, SEED=0xACE1 → sat=1. Bench checker confirms values satisfies every enabled clause; busy high throughout the search.
5. Deassert reset during FLIP → next cycle busy=0, done=0, values=0. A new start with no reprogramming returns sat=1 (enables cleared).
6. cfg_we to slot0 while busy, and start while busy → both ignored; the search result matches a run without them.

Source files
------------

// File: rtl/walksat_core.sv
// WalkSAT 3SAT engine: programmable clause store, parallel clause evaluation, LFSR-driven flips.
// Latency: start -> INIT -> EVAL; a satisfied formula reports done 3 cycles after start, each flip costs 3 cycles.
// Backpressure: none; cfg_we and start are ignored while busy, results hold in DONE until the next start.
module walksat_core #(
    parameter int          N         = 3,
    parameter int          M         = 4,
    parameter int          K         = 3,
    parameter int          MAX_FLIPS = 8,
    parameter int          MAX_TRIES = 4,
    parameter logic [31:0] SEED      = 32'h1,
    localparam int         VW        = (N > 1) ? $clog2(N) : 1,
    localparam int         LW        = VW + 1,
    localparam int         MW        = (M > 1) ? $clog2(M) : 1,
    localparam int         FW        = $clog2(MAX_FLIPS + 1),
    localparam int         TW        = $clog2(MAX_TRIES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_we,
    input  logic [MW-1:0] cfg_idx,
    input  logic          cfg_en,
    input  logic [K*LW-1:0] cfg_lits,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          sat,
    output logic [N-1:0]  values,
    output logic [FW-1:0] flip_count,
    output logic [TW-1:0] try_count
);

    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [31:0] TAPS     = 32'h8020_0003;

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_EVAL, S_PICK, S_FLIP, S_DONE} state_t;

    state_t          state;
    logic [31:0]     lfsr;
    logic [31:0]     lfsr_next;
    logic [K*LW-1:0] clause_lits [M];
    logic [M-1:0]    clause_en;
    logic [M-1:0]    sat_now;
    logic [M-1:0]    sat_vec;
    logic            all_sat;
    logic            cfg_ok;
    logic [MW-1:0]   pick_idx;
    logic [MW-1:0]   pick_next;
    logic [K*LW-1:0] pick_lits;
    logic [2*M-1:0]  unsat_dbl;
    int              start_off;
    int              pick_pos;
    int              j_sel;
    logic            flip_ok;
    logic [VW-1:0]   flip_var;

    // A literal whose variable index is out of range is padding and reads as constant 0.
    function automatic logic lit_true(input logic [LW-1:0] lit, input logic [N-1:0] v);
        logic r;
        r = 1'b0;
        for (int b = 0; b < N; b++)
            if (int'(lit[VW-1:0]) == b) r = v[b] ^ lit[LW-1];
        return r;
    endfunction

    function automatic logic lit_valid(input logic [LW-1:0] lit);
        return int'(lit[VW-1:0]) < N;
    endfunction

    assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'h0);
    assign cfg_ok    = cfg_we && (state == S_IDLE || state == S_DONE) && (int'(cfg_idx) < M);
    assign pick_lits = clause_lits[pick_idx];
    assign all_sat   = &sat_now;

    // Evaluate every clause in parallel; a disabled slot counts as satisfied.
    always_comb begin
        sat_now = '0;
        for (int c = 0; c < M; c++) begin
            sat_now[c] = ~clause_en[c];
            for (int j = 0; j < K; j++)
                if (lit_true(clause_lits[c][j*LW +: LW], values)) sat_now[c] = 1'b1;
        end
    end

    // Rotate-priority encoder: first unsatisfied clause at or after a random start slot.
    always_comb begin
        start_off = int'(lfsr[MW-1:0]) % M;
        unsat_dbl = {~sat_vec, ~sat_vec} >> start_off;
        pick_pos  = 0;
        for (int i = M - 1; i >= 0; i--)
            if (unsat_dbl[i]) pick_pos = i;
        pick_next = MW'((start_off + pick_pos) % M);
    end

    // Choose the variable to flip: random literal, falling back to the lowest valid one.
    always_comb begin
        j_sel    = int'(lfsr[1:0]) % K;
        flip_ok  = 1'b0;
        flip_var = '0;
        for (int j = K - 1; j >= 0; j--)
            if (lit_valid(pick_lits[j*LW +: LW])) begin
                flip_ok  = 1'b1;
                flip_var = pick_lits[j*LW +: VW];
            end
        for (int j = 0; j < K; j++)
            if (j == j_sel && lit_valid(pick_lits[j*LW +: LW])) flip_var = pick_lits[j*LW +: VW];
    end

    // Clause literal storage; contents are meaningless until the slot is enabled.
    always_ff @(posedge clk) begin
        if (cfg_ok) clause_lits[cfg_idx] <= cfg_lits;
    end

    // Search FSM, LFSR and clause enables.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            sat        <= 1'b0;
            values     <= '0;
            flip_count <= '0;
            try_count  <= '0;
            clause_en  <= '0;
            lfsr       <= SEED_EFF;
            sat_vec    <= '0;
            pick_idx   <= '0;
        end else begin
            lfsr <= lfsr_next;
            if (cfg_ok) clause_en[cfg_idx] <= cfg_en;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_INIT;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        sat        <= 1'b0;
                        try_count  <= TW'(1);
                        flip_count <= '0;
                    end
                end
                S_INIT: begin
                    values     <= lfsr[N-1:0];
                    flip_count <= '0;
                    state      <= S_EVAL;
                end
                S_EVAL: begin
                    sat_vec <= sat_now;
                    if (all_sat) begin
                        state <= S_DONE;
                        sat   <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (flip_count == FW'(MAX_FLIPS)) begin
                        if (try_count == TW'(MAX_TRIES)) begin
                            state <= S_DONE;
                            sat   <= 1'b0;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            try_count <= try_count + TW'(1);
                            state     <= S_INIT;
                        end
                    end else begin
                        state <= S_PICK;
                    end
                end
                S_PICK: begin
                    pick_idx <= pick_next;
                    state    <= S_FLIP;
                end
                S_FLIP: begin
                    if (flip_ok) values <= values ^ (N'(1) << flip_var);
                    flip_count <= flip_count + FW'(1);
                    state      <= S_EVAL;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_walksat_core.sv
// Bench for walksat_core: table of small clause sets on a 3-variable engine plus a 4-variable instance.
// Latency: checks exact done cycles for trivial, failing and interrupted searches.
// Backpressure: exercises config writes and start pulses while busy.
module tb_walksat_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Engine A: N=3, M=4, K=3, 4 flips x 2 tries.
    logic       a_reset, a_cfg_we, a_cfg_en, a_start;
    logic [1:0] a_cfg_idx;
    logic [8:0] a_cfg_lits;
    logic       a_busy, a_done, a_sat;
    logic [2:0] a_values;
    logic [2:0] a_flip;
    logic [1:0] a_try;

    // Engine B: N=4, M=6, K=3, 16 flips x 8 tries.
    logic       b_reset, b_cfg_we, b_cfg_en, b_start;
    logic [2:0] b_cfg_idx;
    logic [8:0] b_cfg_lits;
    logic       b_busy, b_done, b_sat;
    logic [3:0] b_values;
    logic [4:0] b_flip;
    logic [3:0] b_try;

    walksat_core #(.N(3), .M(4), .K(3), .MAX_FLIPS(4), .MAX_TRIES(2), .SEED(32'h1)) dut_a (
        .clk(clk), .reset(a_reset), .cfg_we(a_cfg_we), .cfg_idx(a_cfg_idx), .cfg_en(a_cfg_en),
        .cfg_lits(a_cfg_lits), .start(a_start), .busy(a_busy), .done(a_done), .sat(a_sat),
        .values(a_values), .flip_count(a_flip), .try_count(a_try)
    );

    walksat_core #(.N(4), .M(6), .K(3), .MAX_FLIPS(16), .MAX_TRIES(8), .SEED(32'hACE1)) dut_b (
        .clk(clk), .reset(b_reset), .cfg_we(b_cfg_we), .cfg_idx(b_cfg_idx), .cfg_en(b_cfg_en),
        .cfg_lits(b_cfg_lits), .start(b_start), .busy(b_busy), .done(b_done), .sat(b_sat),
        .values(b_values), .flip_count(b_flip), .try_count(b_try)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent clause model: 3 literals of 3 bits, index >= n is padding.
    function automatic logic clause_ok(input logic [8:0] lits, input logic [3:0] v, input int n);
        logic [2:0] lit;
        logic r;
        r = 1'b0;
        for (int j = 0; j < 3; j++) begin
            lit = lits[j*3 +: 3];
            if (int'(lit[1:0]) < n && (v[lit[1:0]] ^ lit[2])) r = 1'b1;
        end
        return r;
    endfunction

    task automatic a_write(input logic [1:0] idx, input logic en, input logic [8:0] lits);
        a_cfg_we = 1'b1; a_cfg_idx = idx; a_cfg_en = en; a_cfg_lits = lits;
        tick();
        a_cfg_we = 1'b0;
    endtask

    task automatic a_run(input int bound, output int n);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        n = 1;
        while (!a_done && n < bound) begin
            tick();
            n++;
        end
    endtask

    typedef struct {
        logic       en0;
        logic [8:0] l0;
        logic       en1;
        logic [8:0] l1;
        logic       exp_sat;
        int         exp_try;
        int         flip_max;
        logic       flip_exact;
        logic [2:0] vmask;
        logic [2:0] vexp;
    } vec_t;

    vec_t vecs[7];
    logic [8:0] b_cl[6];

    initial begin
        int n;
        logic [2:0] held_vals;
        logic       busy_ok;

        // literal = {neg, idx[1:0]}, packed {lit2, lit1, lit0}; 3'b011 is padding for N=3
        vecs[0] = '{1'b1, 9'b011_011_000, 1'b0, 9'b0,           1'b1, 1, 1, 1'b0, 3'b001, 3'b001};
        vecs[1] = '{1'b1, 9'b011_011_101, 1'b0, 9'b0,           1'b1, 1, 1, 1'b0, 3'b010, 3'b000};
        vecs[2] = '{1'b1, 9'b011_011_000, 1'b1, 9'b011_011_100, 1'b0, 2, 4, 1'b1, 3'b000, 3'b000};
        vecs[3] = '{1'b1, 9'b011_011_011, 1'b0, 9'b0,           1'b0, 2, 4, 1'b1, 3'b000, 3'b000};
        vecs[4] = '{1'b1, 9'b010_001_000, 1'b1, 9'b110_101_100, 1'b1, 1, 1, 1'b0, 3'b000, 3'b000};
        vecs[5] = '{1'b0, 9'b011_011_000, 1'b1, 9'b011_011_100, 1'b1, 1, 1, 1'b0, 3'b001, 3'b000};
        vecs[6] = '{1'b1, 9'b011_010_011, 1'b0, 9'b0,           1'b1, 1, 1, 1'b0, 3'b100, 3'b100};

        b_cl[0] = 9'b110_001_000;  //  x0 |  x1 | ~x2
        b_cl[1] = 9'b011_010_100;  // ~x0 |  x2 |  x3
        b_cl[2] = 9'b010_111_001;  //  x1 | ~x3 |  x2
        b_cl[3] = 9'b000_011_101;  // ~x1 |  x3 |  x0
        b_cl[4] = 9'b011_010_000;  //  x0 |  x2 |  x3
        b_cl[5] = 9'b111_101_100;  // ~x0 | ~x1 | ~x3

        a_reset = 1'b0; a_cfg_we = 1'b0; a_cfg_idx = '0; a_cfg_en = 1'b0; a_cfg_lits = '0; a_start = 1'b0;
        b_reset = 1'b0; b_cfg_we = 1'b0; b_cfg_idx = '0; b_cfg_en = 1'b0; b_cfg_lits = '0; b_start = 1'b0;
        tick(); tick();
        a_reset = 1'b1; b_reset = 1'b1;

        // Reset state
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_sat", a_sat, 0);
        chk("rst_values", a_values, 0);
        chk("rst_flip", a_flip, 0);
        chk("rst_try", a_try, 0);

        // Empty clause store: done exactly 3 cycles after start
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk("t1_busy_init", a_busy, 1);
        chk("t1_done_init", a_done, 0);
        chk("t1_try_init", a_try, 1);
        tick();
        chk("t1_done_eval", a_done, 0);
        tick();
        chk("t1_done", a_done, 1);
        chk("t1_sat", a_sat, 1);
        chk("t1_busy_end", a_busy, 0);
        chk("t1_flip", a_flip, 0);
        chk("t1_try", a_try, 1);

        // Table of clause sets
        for (int i = 0; i < 7; i++) begin
            a_write(2'd0, vecs[i].en0, vecs[i].l0);
            a_write(2'd1, vecs[i].en1, vecs[i].l1);
            a_run(40, n);
            chk($sformatf("v%0d_done", i), a_done, 1);
            chk($sformatf("v%0d_sat", i), a_sat, vecs[i].exp_sat);
            chk($sformatf("v%0d_try", i), a_try, vecs[i].exp_try);
            if (vecs[i].flip_exact)
                chk($sformatf("v%0d_flip", i), a_flip, vecs[i].flip_max);
            else
                chk($sformatf("v%0d_flip_le", i), int'(a_flip <= 3'(vecs[i].flip_max)), 1);
            if (vecs[i].vmask != 3'b000)
                chk($sformatf("v%0d_values", i), a_values & vecs[i].vmask, vecs[i].vexp);
            if (vecs[i].exp_sat)
                chk($sformatf("v%0d_model", i),
                    int'((!vecs[i].en0 || clause_ok(vecs[i].l0, {1'b0, a_values}, 3)) &&
                         (!vecs[i].en1 || clause_ok(vecs[i].l1, {1'b0, a_values}, 3))), 1);
            if (vecs[i].flip_exact)
                chk($sformatf("v%0d_cycles", i), n, 29);
        end

        // Reset while in FLIP aborts and clears the store
        a_write(2'd0, 1'b1, 9'b011_011_000);
        a_write(2'd1, 1'b1, 9'b011_011_100);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        tick(); tick(); tick();
        a_reset = 1'b0;
        tick();
        a_reset = 1'b1;
        chk("t5_busy", a_busy, 0);
        chk("t5_done", a_done, 0);
        chk("t5_values", a_values, 0);
        chk("t5_try", a_try, 0);
        a_run(40, n);
        chk("t5_sat", a_sat, 1);
        chk("t5_cycles", n, 3);
        chk("t5_flip", a_flip, 0);

        // Config write and start while busy are ignored
        a_write(2'd0, 1'b1, 9'b011_011_000);
        a_write(2'd1, 1'b1, 9'b011_011_100);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        n = 1;
        while (!a_done && n < 60) begin
            if (n == 5) begin
                a_cfg_we = 1'b1; a_cfg_idx = 2'd0; a_cfg_en = 1'b0; a_start = 1'b1;
            end else begin
                a_cfg_we = 1'b0; a_start = 1'b0;
            end
            tick();
            n++;
        end
        a_cfg_we = 1'b0; a_start = 1'b0;
        chk("t6_cycles", n, 29);
        chk("t6_sat", a_sat, 0);
        chk("t6_try", a_try, 2);
        chk("t6_flip", a_flip, 4);
        held_vals = a_values;
        tick(); tick(); tick();
        chk("t6_hold_done", a_done, 1);
        chk("t6_hold_values", a_values, held_vals);
        chk("t6_hold_flip", a_flip, 4);
        // a write in DONE takes effect: only x0 remains
        a_write(2'd1, 1'b0, 9'b011_011_100);
        a_run(40, n);
        chk("t6_after_sat", a_sat, 1);
        chk("t6_after_x0", a_values[0], 1);

        // Engine B: satisfiable 4-variable instance
        for (int c = 0; c < 6; c++) begin
            b_cfg_we = 1'b1; b_cfg_idx = 3'(c); b_cfg_en = 1'b1; b_cfg_lits = b_cl[c];
            tick();
        end
        b_cfg_we = 1'b0;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        n = 1;
        busy_ok = 1'b1;
        while (!b_done && n < 1000) begin
            if (!b_busy) busy_ok = 1'b0;
            tick();
            n++;
        end
        chk("t4_done", b_done, 1);
        chk("t4_busy_throughout", busy_ok, 1);
        chk("t4_sat", b_sat, 1);
        for (int c = 0; c < 6; c++)
            chk($sformatf("t4_clause%0d", c), clause_ok(b_cl[c], b_values, 4), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
